// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master drives the operands and start; the slave returns status and the result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a full adder made of two
// half-adder stages, with a single carry flip-flop chaining the bits.
module serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_sa, w_sa_nxt;
  logic [WIDTH-1:0]  r_sb, w_sb_nxt;
  logic [WIDTH-1:0]  r_sr, w_sr_nxt;
  logic [WIDTH-1:0]  r_sum, w_sum_nxt;
  logic              r_cout, w_cout_nxt;
  logic              r_carry, w_carry_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;

  logic              w_p, w_g1, w_s, w_g2, w_c;
  logic              w_last;
  logic [WIDTH-1:0]  w_sr_shift;

  // First half adder on the operand bits, second folds in the carry.
  assign w_p  = r_sa[0] ^ r_sb[0];
  assign w_g1 = r_sa[0] & r_sb[0];
  assign w_s  = w_p ^ r_carry;
  assign w_g2 = w_p & r_carry;
  assign w_c  = w_g1 | w_g2;

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special slice.
  assign w_sr_shift = WIDTH'({w_s, r_sr} >> 1);
  assign w_last     = (r_cnt == CntW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_sa_nxt    = r_sa;
    w_sb_nxt    = r_sb;
    w_sr_nxt    = r_sr;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_nxt = StRun;
          w_sa_nxt    = bus.a;
          w_sb_nxt    = bus.b;
          w_carry_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      StRun: begin
        w_sa_nxt    = r_sa >> 1;
        w_sb_nxt    = r_sb >> 1;
        w_sr_nxt    = w_sr_shift;
        w_carry_nxt = w_c;
        w_cnt_nxt   = r_cnt + CntW'(1);
        if (w_last) begin
          w_state_nxt = StDone;
          w_sum_nxt   = w_sr_shift;
          w_cout_nxt  = w_c;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sa    <= w_sa_nxt;
      r_sb    <= w_sb_nxt;
      r_sr    <= w_sr_nxt;
      r_sum   <= w_sum_nxt;
      r_cout  <= w_cout_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.busy = (r_state == StRun);
  assign bus.done = (r_state == StDone);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table on a WIDTH=4 instance, hand-written
// sequences for ignored start, mid-run reset, start held high, and a WIDTH=1 instance.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_adder_if #(.WIDTH(4)) bus4 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for done on the WIDTH=4 instance, counting busy cycles seen before it.
  task automatic wait_done4(output bit seen, output int lat, output int bcnt);
    seen = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus4.done) begin
        seen = 1'b1;
        lat  = i;
      end else if (bus4.busy) begin
        bcnt++;
      end
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output bit seen, output int lat, output int bcnt);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = a;
    bus4.b     = b;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    wait_done4(seen, lat, bcnt);
  endtask

  task automatic op1(input logic a, input logic b, input logic exp_sum, input logic exp_cout);
    bit seen;
    int lat;
    int bcnt;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    seen = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus1.done) begin
        seen = 1'b1;
        lat  = i;
      end else if (bus1.busy) begin
        bcnt++;
      end
    end
    check("w1_done_seen", 32'(seen), 32'd1);
    check("w1_latency", 32'(lat), 32'd1);
    check("w1_busy_cycles", 32'(bcnt), 32'd1);
    check("w1_sum", 32'(bus1.sum), 32'(exp_sum));
    check("w1_cout", 32'(bus1.cout), 32'(exp_cout));
  endtask

  initial begin
    bit         seen;
    int         lat;
    int         bcnt;
    int         waited;
    int         dones;
    logic [3:0] pa;
    logic [3:0] pb;
    logic [4:0] exp5;

    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{a: 4'd3,  b: 4'd5,  sum: 4'd8,  cout: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  sum: 4'd0,  cout: 1'b1};
    vecs[2] = '{a: 4'd15, b: 4'd15, sum: 4'd14, cout: 1'b1};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  sum: 4'd0,  cout: 1'b0};
    vecs[4] = '{a: 4'd10, b: 4'd6,  sum: 4'd0,  cout: 1'b1};
    vecs[5] = '{a: 4'd6,  b: 4'd9,  sum: 4'd15, cout: 1'b0};

    rst_n      = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus4.busy), 32'd0);
    check("reset_done", 32'(bus4.done), 32'd0);
    check("reset_sum", 32'(bus4.sum), 32'd0);
    check("reset_cout", 32'(bus4.cout), 32'd0);
    check("reset_w1_outs", 32'({bus1.busy, bus1.done, bus1.sum, bus1.cout}), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      op4(vecs[i].a, vecs[i].b, seen, lat, bcnt);
      check("vec_done_seen", 32'(seen), 32'd1);
      check("vec_latency", 32'(lat), 32'd4);
      check("vec_busy_cycles", 32'(bcnt), 32'd4);
      check("vec_sum", 32'(bus4.sum), 32'(vecs[i].sum));
      check("vec_cout", 32'(bus4.cout), 32'(vecs[i].cout));
      @(negedge clk);
      check("vec_done_width", 32'(bus4.done), 32'd0);
    end

    // Ignored start mid-run, operand changes mid-run, result hold during RUN.
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = 4'd2;
    bus4.b     = 4'd3;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    @(negedge clk);
    check("hold_sum_in_run", 32'(bus4.sum), 32'd15);
    check("hold_busy", 32'(bus4.busy), 32'd1);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = 4'd9;
    bus4.b     = 4'd9;
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.a     = 4'd12;
    bus4.b     = 4'd1;
    wait_done4(seen, lat, bcnt);
    check("b2b_done_seen", 32'(seen), 32'd1);
    check("b2b_sum", 32'(bus4.sum), 32'd5);
    check("b2b_cout", 32'(bus4.cout), 32'd0);
    @(negedge clk);
    check("b2b_done_width", 32'(bus4.done), 32'd0);
    bcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus4.busy || bus4.done) bcnt++;
    end
    check("b2b_start_not_queued", 32'(bcnt), 32'd0);

    // Reset in the middle of a run.
    op4(4'd7, 4'd7, seen, lat, bcnt);
    check("pre_rst_sum", 32'(bus4.sum), 32'd14);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = 4'd15;
    bus4.b     = 4'd15;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus4.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(bus4.busy), 32'd0);
    check("rst_mid_sum", 32'(bus4.sum), 32'd0);
    check("rst_mid_cout", 32'(bus4.cout), 32'd0);
    check("rst_mid_done", 32'(bus4.done), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.done) dones++;
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);
    op4(4'd1, 4'd1, seen, lat, bcnt);
    check("post_rst_sum", 32'(bus4.sum), 32'd2);
    check("post_rst_cout", 32'(bus4.cout), 32'd0);
    @(negedge clk);

    // Exhaustive sweep with start held high; operands updated during each DONE cycle.
    @(negedge clk);
    bus4.a     = 4'd0;
    bus4.b     = 4'd0;
    bus4.start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      pa = 4'(k >> 4);
      pb = 4'(k);
      waited = 0;
      seen   = 1'b0;
      for (int j = 0; j < 20 && !seen; j++) begin
        @(negedge clk);
        waited++;
        if (bus4.done) seen = 1'b1;
      end
      if (!seen) begin
        check("sweep_done_timeout", 32'(seen), 32'd1);
        break;
      end
      exp5 = {1'b0, pa} + {1'b0, pb};
      check("sweep_result", 32'({bus4.cout, bus4.sum}), 32'(exp5));
      if (k > 0) check("sweep_done_spacing", 32'(waited), 32'd6);
      bus4.a = 4'((k + 1) >> 4);
      bus4.b = 4'(k + 1);
    end
    bus4.start = 1'b0;
    repeat (8) @(negedge clk);

    op1(1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    op1(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
